// File: rtl/mseq_pkg.sv
// Shared definitions for the micro_sequencer: microinstruction field layout,
// op and condition encodings, sequencer state and the branch-condition selector.
`default_nettype none

package mseq_pkg;

  localparam int S_LSB    = 0;
  localparam int S_W      = 4;
  localparam int M_BIT    = 4;
  localparam int PIN_BIT  = 5;
  localparam int A_BIT    = 6;
  localparam int V_LSB    = 7;
  localparam int V_W      = 4;
  localparam int WR_BIT   = 11;
  localparam int ADR_LSB  = 12;
  localparam int ADR_W    = 3;
  localparam int ISR_BIT  = 15;
  localparam int ISL_BIT  = 16;
  localparam int DIN_LSB  = 17;
  localparam int DIN_W    = 4;
  localparam int COND_LSB = 21;
  localparam int COND_W   = 2;
  localparam int INV_BIT  = 23;
  localparam int OP_LSB   = 24;
  localparam int OP_W     = 3;
  localparam int TGT_LSB  = 27;

  localparam logic [OP_W-1:0] OP_NEXT  = 3'b000;
  localparam logic [OP_W-1:0] OP_JMP   = 3'b001;
  localparam logic [OP_W-1:0] OP_CALL  = 3'b010;
  localparam logic [OP_W-1:0] OP_RET   = 3'b011;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b100;
  localparam logic [OP_W-1:0] OP_LDCNT = 3'b101;
  localparam logic [OP_W-1:0] OP_DJNZ  = 3'b110;
  localparam logic [OP_W-1:0] OP_NEXT2 = 3'b111;

  localparam logic [COND_W-1:0] COND_ALWAYS = 2'b00;
  localparam logic [COND_W-1:0] COND_POUT   = 2'b01;
  localparam logic [COND_W-1:0] COND_Z      = 2'b10;
  localparam logic [COND_W-1:0] COND_OSL    = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Flags are packed as {OSR, OSL, Z, Pout}.
  function automatic logic cond_sel(input logic [COND_W-1:0] cond, input logic [3:0] flags);
    logic sel;
    case (cond)
      COND_ALWAYS: sel = 1'b1;
      COND_POUT:   sel = flags[0];
      COND_Z:      sel = flags[1];
      COND_OSL:    sel = flags[2];
      default:     sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mseq_stack.sv
// mseq_stack: return-address LIFO for CALL/RET; overflow and underflow are
// refused here and reported through o_full/o_empty.
`default_nettype none

module mseq_stack
  import mseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_top
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_top_idx;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
  assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clear) begin
      r_mem[IDX_W'(r_count)] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram control stage driving the RALU from an external
// control store. Define MSEQ_LOOP_COUNTER_EN to enable the LDCNT/DJNZ loop counter.
`default_nettype none

module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int UADDR_W     = 5,
  parameter int STACK_DEPTH = 4,
  parameter int UINSTR_W    = 27 + UADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [UADDR_W-1:0]  i_start_addr,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [UADDR_W-1:0]  o_upc,
  input  logic [UINSTR_W-1:0] i_uinstr,
  input  logic                i_Pout,
  input  logic                i_OSL,
  input  logic                i_OSR,
  input  logic [3:0]          i_R,
  output logic [3:0]          o_S,
  output logic                o_M,
  output logic                o_Pin,
  output logic                o_A,
  output logic [3:0]          o_v,
  output logic                o_wr,
  output logic [2:0]          o_adr,
  output logic                o_ISR,
  output logic                o_ISL,
  output logic [3:0]          o_DataIn
);

  state_t             r_state, w_state_next;
  logic [UADDR_W-1:0] r_upc, w_upc_next, w_upc_inc, w_target, w_top;
  logic [3:0]         r_flags;
  logic               r_done, r_error;
  logic               w_push, w_pop, w_stop, w_err_set, w_full, w_empty;
  logic               w_start_acc, w_taken;
  logic [OP_W-1:0]    w_op;
`ifdef MSEQ_LOOP_COUNTER_EN
  logic [UADDR_W-1:0] r_cnt, w_cnt_next;
`endif

  assign w_op        = i_uinstr[OP_LSB +: OP_W];
  assign w_target    = i_uinstr[TGT_LSB +: UADDR_W];
  assign w_upc_inc   = r_upc + UADDR_W'(1);
  assign w_start_acc = (r_state == ST_IDLE) && i_start;
  // Branch conditions look at status latched during the previous microinstruction.
  assign w_taken     = cond_sel(i_uinstr[COND_LSB +: COND_W], r_flags) ^ i_uinstr[INV_BIT];

  mseq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (UADDR_W)
  ) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_start_acc),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_upc_inc),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_top   (w_top)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_upc_next   = r_upc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_stop       = 1'b0;
    w_err_set    = 1'b0;
`ifdef MSEQ_LOOP_COUNTER_EN
    w_cnt_next   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_RUN;
          w_upc_next   = i_start_addr;
`ifdef MSEQ_LOOP_COUNTER_EN
          w_cnt_next   = '0;
`endif
        end
      end
      ST_RUN: begin
        w_upc_next = w_upc_inc;
        case (w_op)
          OP_NEXT, OP_NEXT2: ;
          OP_JMP: begin
            if (w_taken) w_upc_next = w_target;
          end
          OP_CALL: begin
            if (w_taken) begin
              if (w_full) begin
                w_err_set = 1'b1;
              end else begin
                w_push     = 1'b1;
                w_upc_next = w_target;
              end
            end
          end
          OP_RET: begin
            if (w_taken) begin
              if (w_empty) begin
                w_err_set = 1'b1;
              end else begin
                w_pop      = 1'b1;
                w_upc_next = w_top;
              end
            end
          end
          OP_HALT: w_stop = 1'b1;
`ifdef MSEQ_LOOP_COUNTER_EN
          OP_LDCNT: w_cnt_next = w_target;
          OP_DJNZ: begin
            if (r_cnt != '0) begin
              w_cnt_next = r_cnt - UADDR_W'(1);
              w_upc_next = w_target;
            end
          end
`else
          OP_LDCNT, OP_DJNZ: ;
`endif
          default: ;
        endcase
        // A stop leaves upc on the halting or faulting microinstruction.
        if (w_stop || w_err_set) begin
          w_state_next = ST_IDLE;
          w_upc_next   = r_upc;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (r_state == ST_RUN);
    o_upc    = r_upc;
    o_done   = r_done;
    o_error  = r_error;
    o_S      = '0;
    o_M      = 1'b0;
    o_Pin    = 1'b0;
    o_A      = 1'b0;
    o_v      = '0;
    o_wr     = 1'b0;
    o_adr    = '0;
    o_ISR    = 1'b0;
    o_ISL    = 1'b0;
    o_DataIn = '0;
    if (r_state == ST_RUN) begin
      o_S      = i_uinstr[S_LSB +: S_W];
      o_M      = i_uinstr[M_BIT];
      o_Pin    = i_uinstr[PIN_BIT];
      o_A      = i_uinstr[A_BIT];
      o_v      = i_uinstr[V_LSB +: V_W];
      o_wr     = i_uinstr[WR_BIT];
      o_adr    = i_uinstr[ADR_LSB +: ADR_W];
      o_ISR    = i_uinstr[ISR_BIT];
      o_ISL    = i_uinstr[ISL_BIT];
      o_DataIn = i_uinstr[DIN_LSB +: DIN_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upc   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_upc  <= w_upc_next;
      r_done <= w_stop || w_err_set;
      if (w_start_acc) begin
        r_flags <= '0;
        r_error <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_flags <= {i_OSR, i_OSL, (i_R == 4'd0), i_Pout};
      end
      if (w_err_set) r_error <= 1'b1;
    end
  end

`ifdef MSEQ_LOOP_COUNTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench for micro_sequencer; the loop-counter
// scenario follows MSEQ_LOOP_COUNTER_EN.
`default_nettype none
`timescale 1ns/1ps

module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  start_addr = '0;
  logic        busy, done, error;
  logic [4:0]  upc;
  logic [31:0] uinstr;
  logic        Pout = 1'b0, OSL = 1'b0, OSR = 1'b0;
  logic [3:0]  R = 4'd1;
  logic [3:0]  S, v, DataIn;
  logic        M, Pin, A, wr, ISR, ISL;
  logic [2:0]  adr;
  logic [20:0] ralu;
  logic [31:0] mem [32];

  assign uinstr = mem[upc];
  assign ralu   = {DataIn, ISL, ISR, adr, wr, v, A, Pin, M, S};

  micro_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
    .o_busy(busy), .o_done(done), .o_error(error), .o_upc(upc), .i_uinstr(uinstr),
    .i_Pout(Pout), .i_OSL(OSL), .i_OSR(OSR), .i_R(R),
    .o_S(S), .o_M(M), .o_Pin(Pin), .o_A(A), .o_v(v), .o_wr(wr), .o_adr(adr),
    .o_ISR(ISR), .o_ISL(ISL), .o_DataIn(DataIn)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [4:0]  exp_q[$], obs_q[$];
  logic [20:0] fexp_q[$], fobs_q[$];
  logic        done_end, err_end, err_first, done_after, busy_after, err_after, timeout;
  logic [20:0] ralu_after;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] cond,
                                     input logic inv, input logic [4:0] tgt,
                                     input logic [20:0] f);
    return {tgt, op, inv, cond, f};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = mk(3'b100, 2'b00, 1'b0, 5'd0, 21'd0);
    exp_q.delete();
    fexp_q.delete();
  endtask

  // Pulses start, records upc/fields every busy cycle, then the stop cycle and the one after.
  task automatic run(input logic [4:0] sa);
    obs_q.delete();
    fobs_q.delete();
    timeout   = 1'b1;
    err_first = 1'bx;
    @(negedge clk);
    start = 1'b1;
    start_addr = sa;
    @(negedge clk);
    start = 1'b0;
    start_addr = '0;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) err_first = error;
      if (!busy) begin
        done_end = done;
        err_end  = error;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
        err_after  = error;
        ralu_after = ralu;
        timeout    = 1'b0;
        break;
      end
      obs_q.push_back(upc);
      fobs_q.push_back(ralu);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {busy, done, error}); end
    total++; if (upc !== 5'd0) begin bad++; $display("FAIL reset_upc got=%0d exp=0", upc); end
    total++; if (ralu !== 21'd0) begin bad++; $display("FAIL reset_ralu got=%h exp=0", ralu); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, error, ralu} !== 24'd0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", {busy, done, error, ralu}); end
  endtask

  task automatic test_sequence();
    int n;
    logic [4:0] e, o;
    logic [20:0] fe, fo;
    clear_mem();
    mem[3] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'($urandom));
    mem[4] = mk(3'b111, 2'b00, 1'b0, 5'd0, 21'($urandom));
    mem[5] = mk(3'b100, 2'b00, 1'b0, 5'd0, (21'd6 << 17) | (21'd2 << 12) | (21'd1 << 11));
    for (int i = 3; i <= 5; i++) begin
      exp_q.push_back(5'(i));
      fexp_q.push_back(mem[i][20:0]);
    end
    run(5'd3);
    n = obs_q.size();
    total++; if (timeout) begin bad++; $display("FAIL seq_timeout got=1 exp=0"); end
    total++; if (n != 3) begin bad++; $display("FAIL seq_busy_cycles got=%0d exp=3", n); end
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      fe = fexp_q.pop_front();
      o  = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      fo = (fobs_q.size() > 0) ? fobs_q.pop_front() : 21'bx;
      total++; if (o !== e) begin bad++; $display("FAIL seq_upc got=%0d exp=%0d", o, e); end
      total++; if (fo !== fe) begin bad++; $display("FAIL seq_fields got=%h exp=%h", fo, fe); end
    end
    total++; if (done_end !== 1'b1 || done_after !== 1'b0) begin bad++; $display("FAIL seq_done_pulse got=%b%b exp=10", done_end, done_after); end
    total++; if (ralu_after !== 21'd0 || busy_after !== 1'b0) begin bad++; $display("FAIL seq_idle_out got=%h/%b exp=0/0", ralu_after, busy_after); end
  endtask

  task automatic test_cond_jump();
    logic [4:0] e, o;
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      Pout = (k != 2);
      mem[0] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'd0);
      mem[1] = mk(3'b001, 2'b01, (k == 1), 5'd10, 21'd0);
      exp_q.push_back(5'd0);
      exp_q.push_back(5'd1);
      exp_q.push_back((k == 0) ? 5'd10 : 5'd2);
      run(5'd0);
      total++; if (timeout || obs_q.size() != 3) begin bad++; $display("FAIL jmp%0d_len got=%0d exp=3", k, obs_q.size()); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
        total++; if (o !== e) begin bad++; $display("FAIL jmp%0d_upc got=%0d exp=%0d", k, o, e); end
      end
    end
    Pout = 1'b0;
  endtask

  task automatic test_call_ret();
    logic [4:0] e, o;
    clear_mem();
    mem[7]  = mk(3'b010, 2'b00, 1'b0, 5'd20, 21'd0);
    mem[20] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'd0);
    mem[21] = mk(3'b011, 2'b00, 1'b0, 5'd0, 21'd0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{5'd7, 5'd20, 5'd21, 5'd8};
    run(5'd7);
    total++; if (timeout || obs_q.size() != 4 || err_end !== 1'b0) begin bad++; $display("FAIL call_len got=%0d/%b exp=4/0", obs_q.size(), err_end); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      total++; if (o !== e) begin bad++; $display("FAIL call_upc got=%0d exp=%0d", o, e); end
    end
  endtask

  task automatic test_stack_errors();
    logic [4:0] e, o;
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      mem[i] = mk(3'b010, 2'b00, 1'b0, 5'(i + 1), 21'd0);
      exp_q.push_back(5'(i));
    end
    run(5'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      total++; if (o !== e) begin bad++; $display("FAIL ovf_upc got=%0d exp=%0d", o, e); end
    end
    total++; if (timeout || obs_q.size() != 0) begin bad++; $display("FAIL ovf_len got=%0d extra exp=0", obs_q.size()); end
    total++; if ({err_end, done_end, done_after, err_after, busy_after} !== 5'b11010) begin
      bad++; $display("FAIL ovf_status got=%b exp=11010", {err_end, done_end, done_after, err_after, busy_after});
    end
    mem[12] = mk(3'b011, 2'b00, 1'b0, 5'd0, 21'd0);
    run(5'd12);
    total++; if (timeout || obs_q.size() != 1 || err_end !== 1'b1 || done_end !== 1'b1) begin
      bad++; $display("FAIL udf_status got=%0d/%b%b exp=1/11", obs_q.size(), err_end, done_end);
    end
    mem[30] = mk(3'b100, 2'b00, 1'b0, 5'd0, 21'd0);
    run(5'd30);
    total++; if (err_first !== 1'b0 || err_end !== 1'b0) begin bad++; $display("FAIL err_clear got=%b%b exp=00", err_first, err_end); end
  endtask

  task automatic test_wrap();
    logic [4:0] e, o;
    clear_mem();
    mem[30] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'd0);
    mem[31] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'd0);
    exp_q = '{5'd30, 5'd31, 5'd0};
    run(5'd30);
    total++; if (timeout || obs_q.size() != 3) begin bad++; $display("FAIL wrap_len got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      total++; if (o !== e) begin bad++; $display("FAIL wrap_upc got=%0d exp=%0d", o, e); end
    end
  endtask

  task automatic test_loop_counter();
    logic [4:0] e, o;
    int body;
    clear_mem();
    mem[0] = mk(3'b101, 2'b00, 1'b0, 5'd3, 21'd0);
    mem[1] = mk(3'b000, 2'b00, 1'b0, 5'd0, 21'd0);
    mem[2] = mk(3'b110, 2'b00, 1'b0, 5'd1, 21'd0);
`ifdef MSEQ_LOOP_COUNTER_EN
    exp_q = '{5'd0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd3};
`else
    exp_q = '{5'd0, 5'd1, 5'd2, 5'd3};
`endif
    run(5'd0);
    body = 0;
    foreach (obs_q[i]) if (obs_q[i] == 5'd1) body++;
`ifdef MSEQ_LOOP_COUNTER_EN
    total++; if (body != 4) begin bad++; $display("FAIL loop_body got=%0d exp=4", body); end
`else
    total++; if (body != 1) begin bad++; $display("FAIL loop_body got=%0d exp=1", body); end
`endif
    total++; if (timeout || done_end !== 1'b1) begin bad++; $display("FAIL loop_done got=%b exp=1", done_end); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      total++; if (o !== e) begin bad++; $display("FAIL loop_upc got=%0d exp=%0d", o, e); end
    end
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[9] = mk(3'b001, 2'b00, 1'b0, 5'd9, 21'h1FFFFF);
    @(negedge clk);
    start = 1'b1;
    start_addr = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1 || ralu !== 21'h1FFFFF) begin bad++; $display("FAIL arst_running got=%b/%h exp=1/1fffff", busy, ralu); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, error, upc, ralu} !== 29'd0) begin bad++; $display("FAIL arst_immediate got=%h exp=0", {busy, done, error, upc, ralu}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || upc !== 5'd0) begin bad++; $display("FAIL arst_idle got=%b/%0d exp=0/0", busy, upc); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_sequence();
    test_cond_jump();
    test_call_ret();
    test_stack_errors();
    test_wrap();
    test_loop_counter();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
